// File: rtl/branch_target_buffer_pkg.sv
// Shared definitions for the branch target buffer: 2-bit direction counter
// encoding and default geometry used to derive index/tag slice widths.
package branch_target_buffer_pkg;

    typedef logic [1:0] cnt_t;

    localparam cnt_t CNT_SNT   = 2'b00;
    localparam cnt_t CNT_WNT   = 2'b01;
    localparam cnt_t CNT_WT    = 2'b10;
    localparam cnt_t CNT_ST    = 2'b11;
    localparam cnt_t CNT_RESET = CNT_WNT;
    localparam cnt_t CNT_ALLOC = CNT_WT;

    localparam int BTB_IDX_BITS = 4;
    localparam int BTB_PC_W     = 32;

    // Word-aligned PCs: index starts at bit 2, tag takes everything above it
    function automatic int tag_width(input int pc_w, input int idx_bits);
        return pc_w - idx_bits - 2;
    endfunction

endpackage

// File: rtl/branch_target_buffer_sat_counter2.sv
// Next-state logic for a 2-bit saturating direction counter.
module sat_counter2
    import branch_target_buffer_pkg::*;
(
    input  cnt_t cur,
    input  logic taken,
    output cnt_t next
);

    always_comb begin
        next = cur;
        if (taken && (cur != CNT_ST)) begin
            next = cur + 2'd1;
        end else if (!taken && (cur != CNT_SNT)) begin
            next = cur - 2'd1;
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit direction counters: combinational lookup for IF,
// registered update from EX, and a saturating mispredict counter.
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int IDX_BITS = BTB_IDX_BITS,
    parameter int PC_W     = BTB_PC_W
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic [PC_W-1:0] LookupPC,
    output logic            PredHit,
    output logic            PredTaken,
    output logic [PC_W-1:0] PredTarget,
    input  logic            UpdEn,
    input  logic [PC_W-1:0] UpdPC,
    input  logic            UpdTaken,
    input  logic [PC_W-1:0] UpdTarget,
    input  logic            UpdMispredict,
    output logic [31:0]     MispredictCount
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = tag_width(PC_W, IDX_BITS);

    logic              valid_q  [ENTRIES];
    logic              valid_d  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [TAG_W-1:0]  tag_d    [ENTRIES];
    logic [PC_W-1:0]   target_q [ENTRIES];
    logic [PC_W-1:0]   target_d [ENTRIES];
    cnt_t              cnt_q    [ENTRIES];
    cnt_t              cnt_d    [ENTRIES];
    logic [31:0]       mispredict_count_q;
    logic [31:0]       mispredict_count_d;

    logic [IDX_BITS-1:0] lk_idx;
    logic [TAG_W-1:0]    lk_tag;
    logic [IDX_BITS-1:0] upd_idx;
    logic [TAG_W-1:0]    upd_tag;
    logic                upd_hit;
    cnt_t                upd_cnt_next;
    logic                unused_pc_low;

    assign lk_idx  = LookupPC[IDX_BITS+1:2];
    assign lk_tag  = LookupPC[PC_W-1:IDX_BITS+2];
    assign upd_idx = UpdPC[IDX_BITS+1:2];
    assign upd_tag = UpdPC[PC_W-1:IDX_BITS+2];
    assign unused_pc_low = ^{LookupPC[1:0], UpdPC[1:0]};

    // Lookup sees only registered state, so a same-cycle update is not bypassed
    always_comb begin
        PredHit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        PredTaken  = PredHit && cnt_q[lk_idx][1];
        PredTarget = PredHit ? target_q[lk_idx] : '0;
    end

    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    sat_counter2 u_sat_counter2 (
        .cur   (cnt_q[upd_idx]),
        .taken (UpdTaken),
        .next  (upd_cnt_next)
    );

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        if (UpdEn) begin
            if (upd_hit) begin
                cnt_d[upd_idx] = upd_cnt_next;
                if (UpdTaken) begin
                    target_d[upd_idx] = UpdTarget;
                end
            end else if (UpdTaken) begin
                // Taken miss evicts whatever aliased into this slot
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = UpdTarget;
                cnt_d[upd_idx]    = CNT_ALLOC;
            end
        end
    end

    always_comb begin
        mispredict_count_d = mispredict_count_q;
        if (UpdEn && UpdMispredict && (mispredict_count_q != 32'hFFFF_FFFF)) begin
            mispredict_count_d = mispredict_count_q + 32'd1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_RESET;
            end
            mispredict_count_q <= '0;
        end else begin
            valid_q            <= valid_d;
            tag_q              <= tag_d;
            target_q           <= target_d;
            cnt_q              <= cnt_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign MispredictCount = mispredict_count_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: behavioural model feeds a
// scoreboard queue of expected lookup results compared against the DUT.
module tb_branch_target_buffer;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] LookupPC;
    logic        PredHit;
    logic        PredTaken;
    logic [31:0] PredTarget;
    logic        UpdEn;
    logic [31:0] UpdPC;
    logic        UpdTaken;
    logic [31:0] UpdTarget;
    logic        UpdMispredict;
    logic [31:0] MispredictCount;

    int checks   = 0;
    int failures = 0;

    bit          m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    logic [1:0]  m_cnt   [16];
    logic [31:0] m_mis;

    typedef struct {
        logic        hit;
        logic        taken;
        logic [31:0] tgt;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    branch_target_buffer #(.IDX_BITS(4), .PC_W(32)) dut (
        .Clk             (Clk),
        .Rst             (Rst),
        .LookupPC        (LookupPC),
        .PredHit         (PredHit),
        .PredTaken       (PredTaken),
        .PredTarget      (PredTarget),
        .UpdEn           (UpdEn),
        .UpdPC           (UpdPC),
        .UpdTaken        (UpdTaken),
        .UpdTarget       (UpdTarget),
        .UpdMispredict   (UpdMispredict),
        .MispredictCount (MispredictCount)
    );

    always #5 Clk = ~Clk;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_cnt[i]   = 2'b01;
        end
        m_mis = '0;
    endtask

    task automatic model_update(input logic [31:0] pc, input logic taken,
                                input logic [31:0] tgt, input logic mis);
        int idx;
        idx = int'(pc[5:2]);
        if (m_valid[idx] && m_tag[idx] == pc[31:6]) begin
            if (taken) begin
                if (m_cnt[idx] != 2'b11) m_cnt[idx] = m_cnt[idx] + 2'd1;
                m_tgt[idx] = tgt;
            end else if (m_cnt[idx] != 2'b00) begin
                m_cnt[idx] = m_cnt[idx] - 2'd1;
            end
        end else if (taken) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = pc[31:6];
            m_tgt[idx]   = tgt;
            m_cnt[idx]   = 2'b10;
        end
        if (mis && m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 32'd1;
    endtask

    function automatic exp_t predict(input logic [31:0] pc, input string name);
        exp_t e;
        int   idx;
        idx     = int'(pc[5:2]);
        e.name  = name;
        e.hit   = m_valid[idx] && (m_tag[idx] == pc[31:6]);
        e.taken = e.hit && m_cnt[idx][1];
        e.tgt   = e.hit ? m_tgt[idx] : 32'h0;
        return e;
    endfunction

    // Drive a lookup, queue the model's expectation, then compare after settling
    task automatic lookup_check(input logic [31:0] pc, input string name);
        exp_t e;
        LookupPC = pc;
        exp_q.push_back(predict(pc, name));
        #1;
        e = exp_q.pop_front();
        checks++;
        if (PredHit !== e.hit) begin
            failures++;
            $display("[TB] FAIL %s hit: got %b expected %b", e.name, PredHit, e.hit);
        end
        checks++;
        if (PredTaken !== e.taken) begin
            failures++;
            $display("[TB] FAIL %s taken: got %b expected %b", e.name, PredTaken, e.taken);
        end
        checks++;
        if (PredTarget !== e.tgt) begin
            failures++;
            $display("[TB] FAIL %s target: got %h expected %h", e.name, PredTarget, e.tgt);
        end
    endtask

    task automatic update(input logic [31:0] pc, input logic taken,
                          input logic [31:0] tgt, input logic mis);
        @(negedge Clk);
        UpdEn         = 1'b1;
        UpdPC         = pc;
        UpdTaken      = taken;
        UpdTarget     = tgt;
        UpdMispredict = mis;
        @(posedge Clk);
        model_update(pc, taken, tgt, mis);
        #1;
        UpdEn         = 1'b0;
        UpdMispredict = 1'b0;
    endtask

    task automatic check_taken(input logic [31:0] pc, input logic want, input string name);
        LookupPC = pc;
        #1;
        checks++;
        if (PredTaken !== want) begin
            failures++;
            $display("[TB] FAIL %s: PredTaken got %b expected %b", name, PredTaken, want);
        end
    endtask

    task automatic check_count(input logic [31:0] want, input string name);
        checks++;
        if (MispredictCount !== want) begin
            failures++;
            $display("[TB] FAIL %s: MispredictCount got %h expected %h", name, MispredictCount, want);
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        model_reset();
        LookupPC = 32'h0040_0010;
        #1;
        lookup_check(32'h0040_0010, "reset_lookup");
        check_count(32'h0, "reset_count");
        @(negedge Clk);
        Rst = 1'b0;
        lookup_check(32'h0040_0010, "post_reset_lookup");
        check_count(m_mis, "post_reset_count");
    endtask

    task automatic test_alloc_hit();
        @(negedge Clk);
        UpdEn     = 1'b1;
        UpdPC     = 32'h0040_0020;
        UpdTaken  = 1'b1;
        UpdTarget = 32'h0040_0100;
        LookupPC  = 32'h0040_0020;
        #1;
        checks++;
        if (PredHit !== 1'b0) begin
            failures++;
            $display("[TB] FAIL same_cycle_no_bypass: PredHit got %b expected 0", PredHit);
        end
        @(posedge Clk);
        model_update(32'h0040_0020, 1'b1, 32'h0040_0100, 1'b0);
        #1;
        UpdEn = 1'b0;
        lookup_check(32'h0040_0020, "alloc_hit");
        checks++;
        if (PredTarget !== 32'h0040_0100) begin
            failures++;
            $display("[TB] FAIL alloc_target: got %h expected 00400100", PredTarget);
        end
        lookup_check(32'h0040_0023, "alloc_low_bits_ignored");
    endtask

    task automatic test_hysteresis();
        update(32'h0040_0020, 1'b0, 32'h0, 1'b0);
        check_taken(32'h0040_0020, 1'b0, "hyst_nt1");
        lookup_check(32'h0040_0020, "hyst_nt1_model");
        update(32'h0040_0020, 1'b0, 32'h0, 1'b0);
        lookup_check(32'h0040_0020, "hyst_nt2_still_valid");
        update(32'h0040_0020, 1'b1, 32'h0040_0100, 1'b0);
        check_taken(32'h0040_0020, 1'b0, "hyst_t1");
        update(32'h0040_0020, 1'b1, 32'h0040_0100, 1'b0);
        check_taken(32'h0040_0020, 1'b1, "hyst_t2");
        for (int i = 0; i < 3; i++) update(32'h0040_0020, 1'b1, 32'h0040_0100, 1'b0);
        update(32'h0040_0020, 1'b0, 32'h0, 1'b0);
        check_taken(32'h0040_0020, 1'b1, "hyst_saturated_high");
        lookup_check(32'h0040_0020, "hyst_final_model");
    endtask

    task automatic test_nt_miss();
        update(32'h0040_0030, 1'b0, 32'h0040_0300, 1'b0);
        lookup_check(32'h0040_0030, "nt_miss_no_alloc");
    endtask

    task automatic test_alias();
        update(32'h0040_0060, 1'b1, 32'h0040_0200, 1'b0);
        lookup_check(32'h0040_0020, "alias_evicted");
        lookup_check(32'h0040_0060, "alias_new_entry");
        update(32'h0040_0060, 1'b0, 32'h0, 1'b0);
        check_taken(32'h0040_0060, 1'b0, "alias_alloc_weak_taken");
        lookup_check(32'h0040_0060, "alias_after_nt");
    endtask

    task automatic test_mispredict();
        for (int i = 0; i < 5; i++) update(32'h0040_0030, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            UpdEn         = 1'b0;
            UpdMispredict = 1'b1;
            @(posedge Clk);
            #1;
        end
        UpdMispredict = 1'b0;
        check_count(m_mis, "mis_count_model");
        check_count(32'd5, "mis_count_five");
        @(negedge Clk);
        force dut.mispredict_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.mispredict_count_q;
        m_mis = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) update(32'h0040_0030, 1'b0, 32'h0, 1'b1);
        check_count(m_mis, "mis_saturate_model");
        check_count(32'hFFFF_FFFF, "mis_saturate");
        @(negedge Clk);
        #2;
        Rst = 1'b1;
        model_reset();
        #1;
        check_count(32'h0, "async_reset_count");
        lookup_check(32'h0040_0060, "async_reset_lookup");
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    initial begin
        UpdEn         = 1'b0;
        UpdPC         = '0;
        UpdTaken      = 1'b0;
        UpdTarget     = '0;
        UpdMispredict = 1'b0;
        LookupPC      = '0;
        test_reset();
        test_alloc_hit();
        test_hysteresis();
        test_nt_miss();
        test_alias();
        test_mispredict();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
Direct-mapped branch target buffer with 2-bit saturating direction predictors, sitting in the instruction-fetch stage of the pipelined MIPS core and feeding next-PC selection. IF gets its prediction combinationally in the same cycle. EX resolves branches and writes the outcome back. A free-running mispredict counter is exported for performance visibility at the top level.

Parameters:
IDX_BITS, 4, log2 of entry count (16 entries)
PC_W, 32, PC/target width in bits

Ports:
Clk  input  1  system clock, rising edge
Rst  input  1  asynchronous active-high reset
LookupPC  input  PC_W  fetch-stage PC
PredHit  output  1  valid entry with matching tag at LookupPC
PredTaken  output  1  PredHit and counter MSB set
PredTarget  output  PC_W  stored target; 0 when PredHit=0
UpdEn  input  1  EX resolved a branch this cycle
UpdPC  input  PC_W  PC of resolved branch
UpdTaken  input  1  actual direction
UpdTarget  input  PC_W  actual target (meaningful when UpdTaken=1)
UpdMispredict  input  1  EX detected mispredict (qualified by UpdEn)
MispredictCount  output  32  saturating mispredict total

Behaviour:
- Reset (async, Rst=1): all valid bits 0, all counters 2'b01, all tags/targets 0, MispredictCount 0. PredHit/PredTaken/PredTarget therefore read 0 immediately while Rst is high. Reset mid-update discards the update.
- Index = PC[IDX_BITS+1:2]; tag = PC[PC_W-1:IDX_BITS+2]; PC[1:0] ignored.
- Lookup: purely combinational, zero latency. Hit = valid[idx] && tag[idx]==LookupPC tag.
- Update: registered on rising Clk when UpdEn=1 and Rst=0. Effects are visible to lookup from the following cycle.
  - Hit on UpdPC, UpdTaken=1: counter saturating +1 (3 stays 3); target <= UpdTarget.
  - Hit, UpdTaken=0: counter saturating -1 (0 stays 0); target unchanged; entry stays valid.
  - Miss (invalid or tag mismatch), UpdTaken=1: allocate. Set valid=1, tag, target=UpdTarget, counter=2'b10 (weakly taken). Any previous occupant is evicted.
  - Miss, UpdTaken=0: no allocation; array unchanged.
- Simultaneous lookup and update to the same index: lookup returns pre-update contents. There is no write-to-read bypass.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T. Prediction = MSB.
- MispredictCount: +1 on each edge with UpdEn && UpdMispredict. It saturates at 32'hFFFF_FFFF and does not wrap. UpdMispredict with UpdEn=0 is ignored.
- UpdEn=0: no state change at all.
- Storage: flop arrays with per-entry async reset. No RAM inference is required.

Decomposition:
- Shared package: counter encoding constants (CNT_SNT, CNT_WNT, CNT_WT, CNT_ST), CNT_RESET=CNT_WNT, CNT_ALLOC=CNT_WT, index/tag slice helper widths derived from IDX_BITS/PC_W.
- One sub-module, sat_counter2: combinational next-state for the 2-bit counter.
  - Inputs: cur, taken.
  - Output: next.
  - Instantiated once on the update path.
- The top of the block holds arrays, lookup compare and the mispredict counter.

Test Plan:
- Reset: Rst=1 with arbitrary LookupPC=0x0040_0010 -> PredHit=0, PredTaken=0, PredTarget=0, MispredictCount=0. Release Rst -> outputs unchanged.
- Allocate/hit: UpdEn, UpdPC=0x0040_0020, UpdTaken=1, UpdTarget=0x0040_0100. Next cycle LookupPC=0x0040_0020 -> PredHit=1, PredTaken=1, PredTarget=0x0040_0100. Same-cycle lookup -> PredHit=0.
- Hysteresis: from allocated (10), two not-taken updates -> after first, PredTaken=0 (01). After second, counter 00. One taken -> still PredTaken=0 (01). Second taken -> PredTaken=1. Three extra taken -> counter holds 11.
- Not-taken miss: UpdPC=0x0040_0030, UpdTaken=0 on empty entry -> lookup PredHit=0 next cycle.
- Alias eviction: allocate 0x0040_0020, then taken update 0x0040_0060 (same index for IDX_BITS=4) with target 0x0040_0200 -> lookup 0x0040_0020 PredHit=0; 0x0040_0060 hits with 0x0040_0200 and counter 10.
- Mispredict counter: 5 edges UpdEn=1 UpdMispredict=1 plus 3 edges UpdEn=0 UpdMispredict=1 -> MispredictCount=5. Force internal value 32'hFFFF_FFFE, apply 3 mispredicts -> 32'hFFFF_FFFF. Assert Rst asynchronously mid-cycle -> 0 immediately.
